hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage RISC-V core. It drives the write_en and flush inputs of every pipe_reg instance: IF/ID, ID/EX, EX/MEM and MEM/WB.
- It detects load-use hazards, taken branches and data-memory wait states, then issues stall/flush patterns from those inputs.
- Sits beside the datapath; its outputs connect directly to the pipe_reg controls and the PC write enable.
- Keeps saturating stall/flush event counters and a sticky memory-timeout error flag.

Parameters:
- CNT_W, 16, width of stall_cnt and flush_cnt (saturating).
- MEM_TIMEOUT, 64, consecutive MEM_WAIT cycles after which timeout_err sets.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- id_rs1  input  5  rs1 of the instruction in ID.
- id_rs2  input  5  rs2 of the instruction in ID.
- id_rs1_used  input  1  ID instruction reads rs1.
- id_rs2_used  input  1  ID instruction reads rs2.
- ex_rd  input  5  destination register of the instruction in EX.
- ex_mem_read  input  1  EX instruction is a load.
- ex_branch_taken  input  1  EX resolved a taken branch or jump.
- mem_req  input  1  MEM stage has an active data-memory access.
- mem_ready  input  1  data memory completes the access this cycle.
- pc_we  output  1  PC write enable.
- ifid_we, ifid_flush  output  1 each  IF/ID controls.
- idex_we, idex_flush  output  1 each  ID/EX controls.
- exmem_we, exmem_flush  output  1 each  EX/MEM controls.
- memwb_we, memwb_flush  output  1 each  MEM/WB controls.
- stall_cnt  output  CNT_W  cycles in which pc_we=0, excluding reset cycles.
- flush_cnt  output  CNT_W  taken-branch flush events.
- timeout_err  output  1  sticky; memory wait exceeded MEM_TIMEOUT.
- state  output  2  current FSM state, for debug.

Behaviour:
- One clock, clk. Synchronous active-high reset rst.
- The FSM and counters are registered. Control outputs are combinational from the current state and inputs; each has a single driver.
- Default (no event): every *_we=1 and every *_flush=0.

States:
- RUN=0, MEM_WAIT=1, LU_STALL=2.
- LU_STALL lasts exactly one cycle, then returns to RUN.

Event detection and priority (highest first):
1. Memory wait: mem_req && !mem_ready.
   - pc_we, ifid_we, idex_we and exmem_we = 0.
   - memwb_flush = 1, so a bubble enters WB.
   - Next state is MEM_WAIT.
   - While in MEM_WAIT, this pattern holds every cycle until mem_ready=1.
   - On the mem_ready=1 cycle the pattern is normal (memwb_flush=0), all other rules are evaluated, and the FSM returns to RUN.
2. Taken branch: ex_branch_taken=1, not in a memory wait.
   - ifid_flush = 1 and idex_flush = 1; pc_we = 1.
   - A simultaneous load-use hazard is ignored because the ID instruction is squashed.
   - flush_cnt increments.
3. Load-use: ex_mem_read && ex_rd!=0 && ((id_rs1_used && id_rs1==ex_rd) || (id_rs2_used && id_rs2==ex_rd)).
   - pc_we = 0, ifid_we = 0, idex_flush = 1.
   - Next state is LU_STALL.
   - In LU_STALL the hazard is re-evaluated normally; the bubble in EX clears it.
- x0 never causes a hazard.

Counters and error flag:
- stall_cnt increments in each cycle where pc_we=0 and rst=0. It saturates at 2^CNT_W-1.
- flush_cnt saturates in the same way.
- A wait counter counts consecutive MEM_WAIT cycles and clears on exit.
  - When it reaches MEM_TIMEOUT, timeout_err is set.
  - timeout_err stays set until rst.
  - The stall itself continues; there is no forced abort.

Reset:
- While rst=1: all *_we=0 and all *_flush=1.
- At the clock edge: state=RUN, counters=0, timeout_err=0.
- Reset asserted during MEM_WAIT or LU_STALL aborts immediately; the first cycle after deassertion is RUN.

Test Plan:
- Reset: rst=1 for 2 cycles → all we=0, all flush=1. After release: all we=1, flush=0, stall_cnt=0, flush_cnt=0, state=0.
- Load-use:
  - ex_mem_read=1, ex_rd=5, id_rs2=5, id_rs2_used=1 → for 1 cycle pc_we=0, ifid_we=0, idex_flush=1, state goes to 2. Next cycle (inputs cleared) back to normal, stall_cnt=1.
  - Repeat with ex_rd=0 → no stall.
- Branch: ex_branch_taken=1 together with a load-use match → ifid_flush=1, idex_flush=1, pc_we=1, flush_cnt=1, stall_cnt unchanged.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then mem_ready=1 →
  - pc/ifid/idex/exmem_we=0 and memwb_flush=1 for 3 cycles, state=1.
  - 4th cycle normal; stall_cnt=3.
  - A branch asserted during the wait has no effect until mem_ready.
- Timeout: MEM_TIMEOUT=4, hold the wait 6 cycles → timeout_err rises after the 4th wait cycle and stays 1 after the wait ends, until rst.
- Saturation and reset mid-stall:
  - CNT_W=2, 5 load-use stalls → stall_cnt=3.
  - Assert rst during MEM_WAIT → the next post-reset cycle has state=0 and counters=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control for the 5-stage core: drives the pipe_reg write
// enables and flushes, plus the PC write enable. It detects memory waits,
// taken branches and load-use hazards, and keeps saturating stall/flush
// counters and a sticky memory-timeout flag.
module hazard_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_flush,
  output logic             exmem_we,
  output logic             exmem_flush,
  output logic             memwb_we,
  output logic             memwb_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             timeout_err,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    LU_STALL = 2'd2
  } state_t;

  localparam int unsigned WC_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [WC_W-1:0]  WC_ONE  = WC_W'(1);
  localparam logic [WC_W-1:0]  WC_MAX  = WC_W'(MEM_TIMEOUT);
  localparam logic [WC_W-1:0]  WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  state_t          cur_state;
  state_t          nxt_state;
  logic            mem_wait;
  logic            load_use;
  logic            flush_ev;
  logic [WC_W-1:0] wait_cnt;

  // Once in MEM_WAIT the stall holds until the memory reports ready.
  assign mem_wait = (mem_req || (cur_state == MEM_WAIT)) && !mem_ready;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  assign flush_ev = !rst && !mem_wait && ex_branch_taken;

  assign state = cur_state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) cur_state <= RUN;
    else     cur_state <= nxt_state;
  end

  // Next state and pipeline controls, by event priority.
  always_comb begin
    nxt_state   = RUN;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_we     = 1'b1;
    idex_flush  = 1'b0;
    exmem_we    = 1'b1;
    exmem_flush = 1'b0;
    memwb_we    = 1'b1;
    memwb_flush = 1'b0;
    if (rst) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_we     = 1'b0;
      idex_flush  = 1'b1;
      exmem_we    = 1'b0;
      exmem_flush = 1'b1;
      memwb_we    = 1'b0;
      memwb_flush = 1'b1;
    end else if (mem_wait) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      exmem_we    = 1'b0;
      memwb_flush = 1'b1;
      nxt_state   = MEM_WAIT;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (load_use) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_flush  = 1'b1;
      nxt_state   = LU_STALL;
    end
  end

  // Saturating event counters, wait-length tracking and sticky timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (!pc_we && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
      if (flush_ev && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_ONE;
      if (mem_wait) begin
        if (wait_cnt != WC_MAX) wait_cnt <= wait_cnt + WC_ONE;
        if (wait_cnt >= WC_LAST) timeout_err <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule
